// File: rtl/mux_scan_sel.sv
// Registered CHANNELS-to-1 word selector with active-low enable.
// Manual select or auto-scan over unmasked channels with per-channel dwell.
module mux_scan_sel #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 2,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      e_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      scan_done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STALL
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               y_valid_q;
  logic [SEL_W-1:0]   cur_sel_q;
  logic               scan_done_q;
  logic [7:0]         dwell_q;

  logic [WIDTH-1:0]   ch [CHANNELS];
  logic               sel_ok;
  logic               any_set;
  logic               last_dwell;
  logic [SEL_W-1:0]   lo_sel;
  logic [SEL_W-1:0]   nx_sel;
  logic               nx_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign ch[g] = din[g*WIDTH +: WIDTH];
  end

  assign sel_ok     = 32'(sel) < CHANNELS;
  assign any_set    = |ch_mask;
  assign last_dwell = dwell_q == 8'(DWELL - 1);

  // Lowest set bit, and next set bit strictly above cur_sel (else wrap).
  always_comb begin
    lo_sel = '0;
    nx_sel = '0;
    nx_hit = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo_sel = SEL_W'(i);
        if (SEL_W'(i) > cur_sel_q) begin
          nx_sel = SEL_W'(i);
          nx_hit = 1'b1;
        end
      end
    end
    if (!nx_hit) nx_sel = lo_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      cur_sel_q   <= '0;
      scan_done_q <= 1'b0;
      dwell_q     <= '0;
    end else if (e_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      scan_done_q <= 1'b0;
      dwell_q     <= '0;
    end else if (!mode) begin
      state_q     <= IDLE;
      scan_done_q <= 1'b0;
      dwell_q     <= '0;
      cur_sel_q   <= sel;
      y_q         <= sel_ok ? ch[sel] : '0;
      y_valid_q   <= sel_ok;
    end else begin
      unique case (state_q)
        IDLE, STALL: begin
          y_q         <= '0;
          y_valid_q   <= 1'b0;
          scan_done_q <= 1'b0;
          dwell_q     <= '0;
          if (any_set) begin
            cur_sel_q <= lo_sel;
            state_q   <= SCAN;
          end else begin
            state_q   <= STALL;
          end
        end
        SCAN: begin
          y_q         <= ch[cur_sel_q];
          y_valid_q   <= 1'b1;
          scan_done_q <= 1'b0;
          if (last_dwell) begin
            dwell_q <= '0;
            if (any_set) begin
              cur_sel_q   <= nx_sel;
              scan_done_q <= ~nx_hit;
            end else begin
              state_q <= STALL;
            end
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign cur_sel   = cur_sel_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel: directed scenarios plus
// randomized auto-scan checked against a set-bit list model.
module tb_mux_scan_sel;
  localparam int W  = 4;
  localparam int C  = 4;
  localparam int D  = 2;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n, e_n, mode;
  logic [SW-1:0]  sel;
  logic [C-1:0]   ch_mask;
  logic [C*W-1:0] din;
  logic [W-1:0]   y;
  logic           y_valid;
  logic [SW-1:0]  cur_sel;
  logic           scan_done;

  int checks = 0;
  int errors = 0;

  localparam logic [C*W-1:0] DIN_FIX = 16'hDCBA;

  always #5 clk = ~clk;

  mux_scan_sel #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
    .clk(clk), .rst_n(rst_n), .e_n(e_n), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .din(din), .y(y), .y_valid(y_valid),
    .cur_sel(cur_sel), .scan_done(scan_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scan model: the k-th edge after entry reads the channel at list
  // position (k-1)/D and leaves cur_sel at list position k/D.
  task automatic run_scan(input logic [C-1:0] m, input int n_edges,
                          input bit rnd);
    int lst[$];
    int n, cb, ca;
    logic [C*W-1:0] dused;
    logic [W-1:0] ey;
    logic ed;
    for (int i = 0; i < C; i++) if (m[i]) lst.push_back(i);
    n = lst.size();
    e_n = 1'b0; mode = 1'b0; sel = '0;
    tick();
    ch_mask = m; mode = 1'b1;
    tick();
    checks++;
    if (y_valid !== 1'b0 || y !== '0) begin
      errors++;
      $display("FAIL scan_entry y=%h v=%b want 0/0", y, y_valid);
    end
    checks++;
    if (cur_sel !== SW'(lst[0])) begin
      errors++;
      $display("FAIL scan_entry_sel got %0d want %0d", cur_sel, lst[0]);
    end
    for (int k = 1; k <= n_edges; k++) begin
      if (rnd) din = (C*W)'($urandom);
      dused = din;
      tick();
      cb = lst[((k - 1) / D) % n];
      ca = lst[(k / D) % n];
      ey = dused[cb*W +: W];
      ed = (k % D == 0) && ((k / D) % n == 0);
      checks++;
      if (y !== ey || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL scan_y m=%b k=%0d got %h/%b want %h/1",
                 m, k, y, y_valid, ey);
      end
      checks++;
      if (cur_sel !== SW'(ca) || scan_done !== ed) begin
        errors++;
        $display("FAIL scan_sel m=%b k=%0d got %0d/%b want %0d/%b",
                 m, k, cur_sel, scan_done, ca, ed);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y !== '0 || y_valid !== 1'b0 || cur_sel !== '0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL reset got y=%h v=%b s=%0d d=%b want zeros",
               y, y_valid, cur_sel, scan_done);
    end
    tick();
    checks++;
    if (y !== '0 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got y=%h v=%b want 0/0", y, y_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_disable();
    din = DIN_FIX;
    run_scan(4'b1111, 3, 1'b0);
    e_n = 1'b1;
    din = '1;
    for (int i = 0; i < 4; i++) begin
      mode = 1'($urandom_range(0, 1));
      sel = SW'($urandom_range(0, 3));
      tick();
      checks++;
      if (y !== '0 || y_valid !== 1'b0 || scan_done !== 1'b0 || cur_sel !== 2'd1) begin
        errors++;
        $display("FAIL disable i=%0d got y=%h v=%b d=%b s=%0d want 0/0/0/1",
                 i, y, y_valid, scan_done, cur_sel);
      end
    end
  endtask

  task automatic test_manual();
    logic [W-1:0] ey;
    e_n = 1'b0; mode = 1'b0; din = DIN_FIX;
    for (int s = 0; s < C; s++) begin
      sel = SW'(s);
      ey = din[s*W +: W];
      tick();
      checks++;
      if (y !== ey || y_valid !== 1'b1 || cur_sel !== SW'(s) || scan_done !== 1'b0) begin
        errors++;
        $display("FAIL manual_dir s=%0d got %h/%b/%0d want %h/1/%0d",
                 s, y, y_valid, cur_sel, ey, s);
      end
    end
    for (int i = 0; i < 20; i++) begin
      sel = SW'($urandom_range(0, C - 1));
      din = (C*W)'($urandom);
      ey = din[sel*W +: W];
      tick();
      checks++;
      if (y !== ey || y_valid !== 1'b1 || cur_sel !== sel) begin
        errors++;
        $display("FAIL manual_rnd i=%0d got %h/%b/%0d want %h/1/%0d",
                 i, y, y_valid, cur_sel, ey, sel);
      end
    end
  endtask

  task automatic test_scan_full();
    din = DIN_FIX;
    run_scan(4'b1111, 18, 1'b0);
  endtask

  task automatic test_mask_change();
    logic [W-1:0] ey [6] = '{4'hD, 4'hD, 4'hB, 4'hB, 4'hB, 4'hB};
    int ec [6] = '{3, 1, 1, 1, 1, 1};
    logic ed [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    din = DIN_FIX;
    run_scan(4'b1010, 6, 1'b0);
    run_scan(4'b1010, 2, 1'b0);
    ch_mask = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (y !== ey[i] || cur_sel !== SW'(ec[i]) || scan_done !== ed[i]) begin
        errors++;
        $display("FAIL mask_change i=%0d got %h/%0d/%b want %h/%0d/%b",
                 i, y, cur_sel, scan_done, ey[i], ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_all_masked();
    din = DIN_FIX;
    run_scan(4'b1111, 1, 1'b0);
    ch_mask = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (y !== '0 || y_valid !== 1'b0 || scan_done !== 1'b0) begin
        errors++;
        $display("FAIL stall i=%0d got %h/%b want 0/0", i, y, y_valid);
      end
    end
    ch_mask = 4'b0100;
    tick();
    checks++;
    if (cur_sel !== 2'd2 || y_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_exit got %0d/%b want 2/0", cur_sel, y_valid);
    end
    tick();
    checks++;
    if (y !== 4'hC || y_valid !== 1'b1 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume got %h/%b/%b want c/1/0", y, y_valid, scan_done);
    end
    tick();
    checks++;
    if (y !== 4'hC || cur_sel !== 2'd2 || scan_done !== 1'b1) begin
      errors++;
      $display("FAIL single_loop got %h/%0d/%b want c/2/1", y, cur_sel, scan_done);
    end
  endtask

  task automatic test_mode_switch();
    din = DIN_FIX;
    run_scan(4'b1111, 3, 1'b0);
    mode = 1'b0; sel = 2'd3; ch_mask = 4'b1100;
    tick();
    checks++;
    if (y !== 4'hD || y_valid !== 1'b1 || cur_sel !== 2'd3) begin
      errors++;
      $display("FAIL to_manual got %h/%b/%0d want d/1/3", y, y_valid, cur_sel);
    end
    mode = 1'b1;
    tick();
    checks++;
    if (y_valid !== 1'b0 || cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL to_auto got %b/%0d want 0/2", y_valid, cur_sel);
    end
    tick();
    checks++;
    if (y !== 4'hC || y_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_auto_y got %h/%b want c/1", y, y_valid);
    end
  endtask

  task automatic test_scan_random();
    for (int it = 0; it < 8; it++) begin
      run_scan(C'($urandom_range(1, (1 << C) - 1)), 2 * C * D + 3, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    din = DIN_FIX;
    run_scan(4'b1111, 5, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (y !== '0 || y_valid !== 1'b0 || cur_sel !== '0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got y=%h v=%b s=%0d d=%b want zeros",
               y, y_valid, cur_sel, scan_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (y_valid !== 1'b0 || cur_sel !== '0) begin
      errors++;
      $display("FAIL post_reset got %b/%0d want 0/0", y_valid, cur_sel);
    end
  endtask

  initial begin
    rst_n = 1'b1; e_n = 1'b1; mode = 1'b0; sel = '0;
    ch_mask = '0; din = '0;
    test_reset();
    test_disable();
    test_manual();
    test_scan_full();
    test_mask_change();
    test_all_masked();
    test_mode_switch();
    test_scan_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
